// File: rtl/fir_output_requant.sv
// fir_output_requant: captures FIR results on the rising edge of Done, rounds
// and saturates them to OUT_WIDTH bits, and queues them in a small FIFO
// presented to the sink over valid/ready. Drop and clip events are counted.
module fir_output_requant #(
  parameter int IN_WIDTH  = 38,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [IN_WIDTH-1:0]   FIR_output,
  input  logic                         Done,
  input  logic                         clr_stats,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic                         overflow,
  output logic [15:0]                  drop_cnt,
  output logic [15:0]                  sat_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic signed [IN_WIDTH:0] HALF =
    {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_WIDTH:0] QMAX =
    {{(IN_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] QMIN = ~QMAX;

  // Round half toward +inf, then clip; result is {sat_flag, sample}.
  function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH:0] sum;
    logic signed [IN_WIDTH:0] q;
    sum = $signed({x[IN_WIDTH-1], x}) + HALF;
    q   = sum >>> SHIFT;
    if (q > QMAX)      return {1'b1, 1'b0, {(OUT_WIDTH - 1){1'b1}}};
    else if (q < QMIN) return {1'b1, 1'b1, {(OUT_WIDTH - 1){1'b0}}};
    else               return {1'b0, q[OUT_WIDTH-1:0]};
  endfunction

  // Statistics counter: a same-edge event beats clear, and the count sticks at all-ones.
  function automatic logic [15:0] stat_next(input logic [15:0] cnt, input logic ev,
                                            input logic clr);
    if (clr)                       return {15'd0, ev};
    else if (ev && cnt != 16'hFFFF) return cnt + 16'd1;
    else                           return cnt;
  endfunction

  logic                        done_q;
  logic                        s1_vld_q;
  logic                        s1_sat_q;
  logic signed [OUT_WIDTH-1:0] s1_data_q;
  logic [OUT_WIDTH:0]          rq;
  logic signed [OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]               level_q, level_d;
  logic                        overflow_q, overflow_d;
  logic [15:0]                 drop_cnt_q, drop_cnt_d;
  logic [15:0]                 sat_cnt_q, sat_cnt_d;
  logic                        capture, pop, push, drop, full_after_pop, sat_ev;

  assign capture        = Done & ~done_q;
  assign rq             = round_sat(FIR_output);
  assign pop            = (level_q != '0) & out_ready;
  assign full_after_pop = (level_q == LW'(DEPTH)) & ~pop;
  assign push           = s1_vld_q & ~full_after_pop;
  assign drop           = s1_vld_q & full_after_pop;
  assign sat_ev         = s1_vld_q & s1_sat_q;

  // Next-state for occupancy and debug statistics.
  always_comb begin
    level_d    = level_q + LW'(push) - LW'(pop);
    overflow_d = clr_stats ? drop : (overflow_q | drop);
    drop_cnt_d = stat_next(drop_cnt_q, drop, clr_stats);
    sat_cnt_d  = stat_next(sat_cnt_q, sat_ev, clr_stats);
  end

  // Control state: edge detector, stage-1 valid, FIFO pointers and stats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_sat_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      sat_cnt_q  <= '0;
    end else begin
      done_q     <= Done;
      s1_vld_q   <= capture;
      s1_sat_q   <= capture & rq[OUT_WIDTH];
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  // Datapath storage: stage-1 sample and FIFO array need no reset.
  always_ff @(posedge clk) begin
    if (capture) s1_data_q <= rq[OUT_WIDTH-1:0];
    if (push)    mem_q[wr_ptr_q] <= s1_data_q;
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_fir_output_requant.sv
// Bench for fir_output_requant: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fir_output_requant;

  localparam int DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [37:0] FIR_output;
  logic               Done;
  logic               clr_stats;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         fifo_level;
  logic               overflow;
  logic [15:0]        drop_cnt;
  logic [15:0]        sat_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fir_output_requant #(.IN_WIDTH(38), .OUT_WIDTH(16), .SHIFT(15), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .FIR_output(FIR_output), .Done(Done), .clr_stats(clr_stats),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt), .sat_cnt(sat_cnt)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference requantizer: plain integer arithmetic on the real value.
  function automatic int requant(input longint v, output bit sat);
    longint q;
    q = (v + 64'sd16384) >>> 15;
    sat = 1'b0;
    if (q > 32767)       begin sat = 1'b1; q = 32767;  end
    else if (q < -32768) begin sat = 1'b1; q = -32768; end
    return int'(q);
  endfunction

  // Behavioural model state.
  int  mq[$];
  bit  m_dprev, m_s1v, m_s1s, m_ovf;
  int  m_s1d, m_drop, m_sat;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_dprev = 0; m_s1v = 0; m_s1s = 0; m_ovf = 0; m_drop = 0; m_sat = 0; m_s1d = 0;
    end else begin
      int  pop, full;
      bit  drop_ev, sat_ev;
      pop     = (mq.size() != 0 && out_ready) ? 1 : 0;
      full    = ((mq.size() - pop) == DEPTH) ? 1 : 0;
      drop_ev = m_s1v && full;
      sat_ev  = m_s1v && m_s1s;
      if (pop != 0) void'(mq.pop_front());
      if (m_s1v && full == 0) mq.push_back(m_s1d);
      if (clr_stats) begin
        m_ovf  = drop_ev;
        m_drop = drop_ev ? 1 : 0;
        m_sat  = sat_ev ? 1 : 0;
      end else begin
        m_ovf = m_ovf | drop_ev;
        if (drop_ev && m_drop < 65535) m_drop++;
        if (sat_ev && m_sat < 65535) m_sat++;
      end
      m_s1v = Done && !m_dprev;
      m_s1s = 0;
      if (m_s1v) m_s1d = requant(longint'(FIR_output), m_s1s);
      m_dprev = Done;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("out_valid", out_valid, (mq.size() != 0) ? 1 : 0);
      check("out_data", longint'(out_data), (mq.size() != 0) ? mq[0] : 0);
      check("fifo_level", fifo_level, mq.size());
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_drop);
      check("sat_cnt", sat_cnt, m_sat);
    end
  end

  // Record every sample accepted by the sink.
  int acc[$];
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid && out_ready) acc.push_back(int'(out_data));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input longint v);
    FIR_output = 38'(v);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b0; FIR_output = '0; Done = 1'b0; clr_stats = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_data", out_data, 0);
    idle(2);
    rst = 1'b1;
    tick();

    // T1 rounding
    out_ready = 1'b1;
    acc.delete();
    pulse(32768); pulse(16384); pulse(16383); pulse(-16384); pulse(-16385);
    idle(3);
    check("t1_count", acc.size(), 5);
    if (acc.size() == 5) begin
      check("t1_s0", acc[0], 1);
      check("t1_s1", acc[1], 1);
      check("t1_s2", acc[2], 0);
      check("t1_s3", acc[3], 0);
      check("t1_s4", acc[4], -1);
    end
    check("t1_sat", sat_cnt, 0);

    // T2 saturation
    acc.delete();
    pulse((64'sd1 << 37) - 1); pulse(-(64'sd1 << 37));
    idle(3);
    check("t2_count", acc.size(), 2);
    if (acc.size() == 2) begin
      check("t2_max", acc[0], 32767);
      check("t2_min", acc[1], -32768);
    end
    check("t2_sat", sat_cnt, 2);

    // T3 latency and Done held high
    out_ready = 1'b0;
    FIR_output = 38'sd65536;
    Done = 1'b1;
    tick();
    check("t3_valid_e1", out_valid, 0);
    tick();
    check("t3_valid_e2", out_valid, 1);
    check("t3_data_e2", out_data, 2);
    idle(3);
    Done = 1'b0;
    tick();
    check("t3_level", fifo_level, 1);
    out_ready = 1'b1;
    idle(2);
    out_ready = 1'b0;

    // T4 overflow
    for (int k = 1; k <= 9; k++) pulse(longint'(k) * 32768);
    idle(2);
    check("t4_level", fifo_level, 8);
    check("t4_ovf", overflow, 1);
    check("t4_drop", drop_cnt, 1);
    acc.delete();
    out_ready = 1'b1;
    idle(10);
    out_ready = 1'b0;
    check("t4_drain_count", acc.size(), 8);
    for (int k = 0; k < 8 && k < acc.size(); k++) check("t4_drain", acc[k], k + 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_drop", drop_cnt, 0);
    check("clr_sat", sat_cnt, 0);

    // T5 full with simultaneous push and pop
    for (int k = 1; k <= 8; k++) pulse(longint'(k) * 32768);
    idle(1);
    check("t5_full", fifo_level, 8);
    FIR_output = 38'(9 * 32768);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    out_ready = 1'b1;
    acc.delete();
    tick();
    out_ready = 1'b0;
    check("t5_level", fifo_level, 8);
    check("t5_drop", drop_cnt, 0);
    check("t5_ovf", overflow, 0);
    out_ready = 1'b1;
    idle(10);
    out_ready = 1'b0;
    check("t5_count", acc.size(), 9);
    if (acc.size() == 9) begin
      check("t5_head", acc[0], 1);
      check("t5_next", acc[1], 2);
      check("t5_tail", acc[8], 9);
    end

    // T6 reset mid-stream with an in-flight sample and Done held high
    pulse(32768); pulse((64'sd1 << 37) - 1); pulse(98304);
    check("t6_level3", fifo_level, 3);
    check("t6_sat1", sat_cnt, 1);
    FIR_output = 38'sd65536;
    Done = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_level", fifo_level, 0);
    check("t6_sat", sat_cnt, 0);
    check("t6_drop", drop_cnt, 0);
    check("t6_ovf", overflow, 0);
    idle(2);
    rst = 1'b1;
    tick();
    check("t6_post_e1", out_valid, 0);
    tick();
    check("t6_post_valid", out_valid, 1);
    check("t6_post_data", out_data, 2);
    idle(2);
    check("t6_post_level", fifo_level, 1);
    Done = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic signed [37:0] v;
      v = 38'({$urandom(), $urandom()});
      v = v >>> $urandom_range(0, 24);
      FIR_output = v;
      Done       = ($urandom_range(0, 99) < 35);
      out_ready  = ($urandom_range(0, 99) < 45);
      clr_stats  = ($urandom_range(0, 99) < 3);
      tick();
    end
    Done = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b1;
    idle(12);
    check("final_empty", fifo_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
